uart_rx_ext: RTL and testbench

UART_RX_EXT -- requirements
Module: uart_rx_ext

---
 rtl/uart_rx_ext.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with majority-vote bit decisions, optional parity,
// one or two stop bits, framing/parity error flags and break detection.
module uart_rx_ext #(
    parameter int unsigned OVERSAMPLING = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic                 perr,
    output logic                 brk
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLING);

    localparam logic [CNT_W-1:0] MID_LO  = CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [CNT_W-1:0] MID     = CNT_W'(OVERSAMPLING / 2);
    localparam logic [CNT_W-1:0] MID_HI  = CNT_W'(OVERSAMPLING / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLING - 1);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       HAS_PAR   = (PARITY != 0);
    localparam logic       ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    state_e               r_state;
    state_e               w_state_d;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_d;
    logic [3:0]           r_bit_idx;
    logic [3:0]           w_bit_idx_d;
    logic [1:0]           r_votes;
    logic [1:0]           w_votes_d;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_d;
    logic                 r_par_acc;
    logic                 w_par_acc_d;
    logic                 r_zero;
    logic                 w_zero_d;
    logic                 r_ferr;
    logic                 w_ferr_d;
    logic [DATA_BITS-1:0] r_out;
    logic [DATA_BITS-1:0] w_out_d;
    logic                 r_done;
    logic                 w_done_d;
    logic                 r_err;
    logic                 w_err_d;
    logic                 r_perr;
    logic                 w_perr_d;
    logic                 r_brk;
    logic                 w_brk_d;

    logic w_in_s;
    logic w_vote;
    logic w_at_hi;
    logic w_at_wrap;
    logic w_ferr_now;
    logic w_zero_now;

    assign w_in_s     = r_sync2;
    assign w_vote     = (r_votes[0] & r_votes[1]) | (r_votes[0] & w_in_s) |
                        (r_votes[1] & w_in_s);
    assign w_at_hi    = (r_cnt == MID_HI);
    assign w_at_wrap  = (r_cnt == CNT_MAX);
    // Stop-bit flags including the vote being decided this cycle.
    assign w_ferr_now = r_ferr | ~w_vote;
    assign w_zero_now = r_zero & ~w_vote;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt + CNT_W'(1);
        w_bit_idx_d = r_bit_idx;
        w_votes_d   = r_votes;
        w_shift_d   = r_shift;
        w_par_acc_d = r_par_acc;
        w_zero_d    = r_zero;
        w_ferr_d    = r_ferr;
        w_out_d     = r_out;
        w_done_d    = 1'b0;
        w_err_d     = 1'b0;
        w_perr_d    = 1'b0;
        w_brk_d     = 1'b0;

        if (r_cnt == MID_LO) w_votes_d[0] = w_in_s;
        if (r_cnt == MID)    w_votes_d[1] = w_in_s;

        if (!en) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_cnt_d = '0;
                    if (!w_in_s) begin
                        w_state_d   = StStart;
                        w_bit_idx_d = '0;
                        w_par_acc_d = 1'b0;
                        w_zero_d    = 1'b1;
                        w_ferr_d    = 1'b0;
                    end
                end
                StStart: begin
                    if (w_at_hi && w_vote) begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end else if (w_at_wrap) begin
                        w_state_d = StData;
                    end
                end
                StData: begin
                    if (w_at_hi) begin
                        w_shift_d   = {w_vote, r_shift[DATA_BITS-1:1]};
                        w_par_acc_d = r_par_acc ^ w_vote;
                        w_zero_d    = r_zero & ~w_vote;
                    end
                    if (w_at_wrap) begin
                        if (r_bit_idx == LAST_DATA) begin
                            w_bit_idx_d = '0;
                            w_state_d   = HAS_PAR ? StParity : StStop;
                        end else begin
                            w_bit_idx_d = r_bit_idx + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (w_at_hi) begin
                        w_par_acc_d = r_par_acc ^ w_vote;
                        w_zero_d    = r_zero & ~w_vote;
                    end
                    if (w_at_wrap) w_state_d = StStop;
                end
                StStop: begin
                    if (w_at_hi) begin
                        if (r_bit_idx == LAST_STOP) begin
                            // Finish mid-bit so the next start edge is not missed.
                            w_out_d   = r_shift;
                            w_done_d  = 1'b1;
                            w_err_d   = w_ferr_now;
                            w_perr_d  = HAS_PAR & (r_par_acc ^ ODD_PAR);
                            w_brk_d   = w_zero_now;
                            w_state_d = w_zero_now ? StWaitIdle : StIdle;
                            w_cnt_d   = '0;
                        end else begin
                            w_ferr_d = w_ferr_now;
                            w_zero_d = w_zero_now;
                        end
                    end else if (w_at_wrap) begin
                        w_bit_idx_d = r_bit_idx + 4'd1;
                    end
                end
                StWaitIdle: begin
                    if (!w_in_s) begin
                        w_cnt_d = '0;
                    end else if (w_at_wrap) begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_votes   <= '0;
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_zero    <= 1'b0;
            r_ferr    <= 1'b0;
            r_out     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_perr    <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            r_sync1   <= in;
            r_sync2   <= r_sync1;
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_bit_idx <= w_bit_idx_d;
            r_votes   <= w_votes_d;
            r_shift   <= w_shift_d;
            r_par_acc <= w_par_acc_d;
            r_zero    <= w_zero_d;
            r_ferr    <= w_ferr_d;
            r_out     <= w_out_d;
            r_done    <= w_done_d;
            r_err     <= w_err_d;
            r_perr    <= w_perr_d;
            r_brk     <= w_brk_d;
        end
    end

    assign out  = r_out;
    assign done = r_done;
    assign busy = (r_state != StIdle);
    assign err  = r_err;
    assign perr = r_perr;
    assign brk  = r_brk;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: a default instance and an even-parity instance.
module tb_uart_rx_ext;

    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       perr;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_a;
    logic       in_b;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       done_a, busy_a, err_a, perr_a, brk_a;
    logic       done_b, busy_b, err_b, perr_b, brk_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    always #5 clk = ~clk;

    uart_rx_ext u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .in   (in_a),
        .out  (out_a),
        .done (done_a),
        .busy (busy_a),
        .err  (err_a),
        .perr (perr_a),
        .brk  (brk_a)
    );

    uart_rx_ext #(
        .PARITY(2)
    ) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .in   (in_b),
        .out  (out_b),
        .done (done_b),
        .busy (busy_b),
        .err  (err_b),
        .perr (perr_b),
        .brk  (brk_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done_a) begin
            if (q_a.size() == 0) begin
                check("unexpected_done_a", {24'd0, out_a}, 32'hffff_ffff);
            end else begin
                e_a = q_a.pop_front();
                check("a_out", {24'd0, out_a}, {24'd0, e_a.data});
                check("a_err", {31'd0, err_a}, {31'd0, e_a.err});
                check("a_perr", {31'd0, perr_a}, {31'd0, e_a.perr});
                check("a_brk", {31'd0, brk_a}, {31'd0, e_a.brk});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done_b) begin
            if (q_b.size() == 0) begin
                check("unexpected_done_b", {24'd0, out_b}, 32'hffff_ffff);
            end else begin
                e_b = q_b.pop_front();
                check("b_out", {24'd0, out_b}, {24'd0, e_b.data});
                check("b_err", {31'd0, err_b}, {31'd0, e_b.err});
                check("b_perr", {31'd0, perr_b}, {31'd0, e_b.perr});
                check("b_brk", {31'd0, brk_b}, {31'd0, e_b.brk});
            end
        end
    end

    task automatic line_set(input int ch, input logic b);
        if (ch == 0) in_a = b;
        else         in_b = b;
    endtask

    // Optional one-clock inversion lands on the middle vote sample.
    task automatic send_bit(input int ch, input logic b, input logic glitch);
        line_set(ch, b);
        if (glitch) begin
            repeat (9) @(negedge clk);
            line_set(ch, ~b);
            @(negedge clk);
            line_set(ch, b);
            repeat (6) @(negedge clk);
        end else begin
            repeat (OS) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int ch, input logic [7:0] data, input logic has_par,
                              input logic par_bit, input logic stop_val,
                              input logic [7:0] gmask);
        send_bit(ch, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(ch, data[i], gmask[i]);
        if (has_par) send_bit(ch, par_bit, 1'b0);
        send_bit(ch, stop_val, 1'b0);
        line_set(ch, 1'b1);
    endtask

    task automatic idle(input int ch, input int n);
        line_set(ch, 1'b1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic seen_busy;
        logic [7:0] v96;
        rst_n = 1'b0;
        en    = 1'b1;
        in_a  = 1'b1;
        in_b  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_done_a", {31'd0, done_a}, 32'd0);
        check("rst_out_a", {24'd0, out_a}, 32'd0);
        check("rst_flags_a", {29'd0, err_a, perr_a, brk_a}, 32'd0);
        check("rst_busy_b", {31'd0, busy_b}, 32'd0);
        rst_n = 1'b1;
        idle(0, 5);

        // Back-to-back frames
        q_a.push_back('{data: 8'h55, err: 1'b0, perr: 1'b0, brk: 1'b0});
        q_a.push_back('{data: 8'h96, err: 1'b0, perr: 1'b0, brk: 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00);
        send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(0, 20);

        // Even parity: 0x96 has four ones, so parity bit 1 is wrong
        q_b.push_back('{data: 8'h96, err: 1'b0, perr: 1'b1, brk: 1'b0});
        send_frame(1, 8'h96, 1'b1, 1'b1, 1'b1, 8'h00);
        idle(1, 20);
        q_b.push_back('{data: 8'h96, err: 1'b0, perr: 1'b0, brk: 1'b0});
        send_frame(1, 8'h96, 1'b1, 1'b0, 1'b1, 8'h00);
        idle(1, 20);

        // Stop bit low, then a normal frame
        q_a.push_back('{data: 8'h55, err: 1'b1, perr: 1'b0, brk: 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(0, 32);
        q_a.push_back('{data: 8'ha5, err: 1'b0, perr: 1'b0, brk: 1'b0});
        send_frame(0, 8'ha5, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(0, 20);

        // Break: 12 bit times low
        q_a.push_back('{data: 8'h00, err: 1'b1, perr: 1'b0, brk: 1'b1});
        line_set(0, 1'b0);
        repeat (12 * OS) @(negedge clk);
        line_set(0, 1'b1);
        repeat (8) @(negedge clk);
        check("wait_idle_busy", {31'd0, busy_a}, 32'd1);
        repeat (16) @(negedge clk);
        check("wait_idle_left", {31'd0, busy_a}, 32'd0);
        q_a.push_back('{data: 8'h55, err: 1'b0, perr: 1'b0, brk: 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(0, 20);

        // Short low glitch on an idle line
        seen_busy = 1'b0;
        line_set(0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (i == 4) line_set(0, 1'b1);
            @(negedge clk);
            seen_busy = seen_busy | busy_a;
        end
        check("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
        check("glitch_busy_clear", {31'd0, busy_a}, 32'd0);
        idle(0, 10);

        // One-clock glitch at every data mid-bit
        q_a.push_back('{data: 8'h96, err: 1'b0, perr: 1'b0, brk: 1'b0});
        send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1, 8'hff);
        idle(0, 20);

        // Reset during data bit 3
        v96 = 8'h96;
        send_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, v96[i], 1'b0);
        line_set(0, v96[3]);
        repeat (8) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_out", {24'd0, out_a}, 32'd0);
        line_set(0, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(0, 40);
        check("post_rst_out", {24'd0, out_a}, 32'd0);
        check("post_rst_busy", {31'd0, busy_a}, 32'd0);

        // Enable dropped during the stop bit
        q_a.push_back('{data: 8'h3c, err: 1'b0, perr: 1'b0, brk: 1'b0});
        send_frame(0, 8'h3c, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(0, 20);
        send_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            v96 = 8'ha3;
            send_bit(0, v96[i], 1'b0);
        end
        line_set(0, 1'b1);
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en_abort_busy", {31'd0, busy_a}, 32'd0);
        repeat (20) @(negedge clk);
        check("en_abort_out", {24'd0, out_a}, 32'h3c);
        en = 1'b1;
        idle(0, 20);
        q_a.push_back('{data: 8'ha3, err: 1'b0, perr: 1'b0, brk: 1'b0});
        send_frame(0, 8'ha3, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(0, 40);

        check("sb_a_drained", q_a.size(), 32'd0);
        check("sb_b_drained", q_b.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
